// File: rtl/systolic_tile_sequencer_pkg.sv
// Shared state encoding and tile-length helpers for the systolic tile sequencer.
package systolic_tile_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic int unsigned max_dim(input int unsigned rows, input int unsigned cols);
    return (rows > cols) ? rows : cols;
  endfunction

  // Number of injection cycles needed for the last operand to enter the far lane.
  function automatic int unsigned feed_window(input int unsigned k_len,
                                              input int unsigned rows,
                                              input int unsigned cols);
    return k_len + max_dim(rows, cols) - 1;
  endfunction

  // Cycles for the wavefront to cross the array after the last injection.
  function automatic int unsigned flush_len(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/systolic_tile_sequencer_skew_mask_gen.sv
// Per-lane injection enables: lane l is active while 0 <= feed_t - l < k_len.
module skew_mask_gen
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned KW    = 8
) (
  input  logic [KW:0]      feed_t_i,
  input  logic [KW-1:0]    k_len_i,
  input  logic             en_i,
  output logic [LANES-1:0] mask_c
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [KW:0] LANE = (KW+1)'(l);
    assign mask_c[l] = en_i && (feed_t_i >= LANE) && ((feed_t_i - LANE) < {1'b0, k_len_i});
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Sequences one output-stationary matmul tile: clear, skewed operand feed,
// wavefront flush, then a one-cycle done/result_valid pulse.
module systolic_tile_sequencer
  import systolic_tile_sequencer_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned KW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [KW-1:0]   k_len,
  output logic            busy,
  output logic            pe_clear,
  output logic [KW:0]     feed_t,
  output logic [ROWS-1:0] a_valid,
  output logic [COLS-1:0] b_valid,
  output logic            result_valid,
  output logic            done
);

  localparam int unsigned FW  = KW + 1;
  localparam int unsigned FLW = $clog2(ROWS + COLS);
  localparam logic [FLW-1:0] FLUSH_LAST = FLW'(flush_len(ROWS, COLS) - 1);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_len_q, k_len_d;
  logic [FW-1:0]   feed_cnt_q, feed_cnt_d;
  logic [FLW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [FW-1:0]   feed_last;

  logic            busy_q, busy_d;
  logic            pe_clear_q, pe_clear_d;
  logic [FW-1:0]   feed_t_q, feed_t_d;
  logic            done_q, done_d;
  logic            feed_en;
  logic [ROWS-1:0] a_valid_q, a_mask_c;
  logic [COLS-1:0] b_valid_q, b_mask_c;

  assign feed_last = FW'(feed_window(32'(k_len_q), ROWS, COLS) - 1);

  // Next state and Moore outputs derived from the next state, so outputs align with state.
  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    feed_cnt_d  = feed_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          k_len_d = k_len;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (k_len_q == '0) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else begin
          state_d    = ST_FEED;
          feed_cnt_d = '0;
        end
      end
      ST_FEED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (feed_cnt_q == feed_last) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else begin
          feed_cnt_d = feed_cnt_q + FW'(1);
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
        end else begin
          flush_cnt_d = flush_cnt_q + FLW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    feed_en    = (state_d == ST_FEED);
    busy_d     = (state_d != ST_IDLE);
    pe_clear_d = (state_d == ST_CLEAR);
    feed_t_d   = feed_en ? feed_cnt_d : '0;
    done_d     = (state_d == ST_DONE);
  end

  skew_mask_gen #(.LANES(ROWS), .KW(KW)) u_a_mask (
    .feed_t_i (feed_t_d),
    .k_len_i  (k_len_d),
    .en_i     (feed_en),
    .mask_c   (a_mask_c)
  );

  skew_mask_gen #(.LANES(COLS), .KW(KW)) u_b_mask (
    .feed_t_i (feed_t_d),
    .k_len_i  (k_len_d),
    .en_i     (feed_en),
    .mask_c   (b_mask_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      feed_cnt_q  <= '0;
      flush_cnt_q <= '0;
      busy_q      <= 1'b0;
      pe_clear_q  <= 1'b0;
      feed_t_q    <= '0;
      done_q      <= 1'b0;
      a_valid_q   <= '0;
      b_valid_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      feed_cnt_q  <= feed_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_q      <= busy_d;
      pe_clear_q  <= pe_clear_d;
      feed_t_q    <= feed_t_d;
      done_q      <= done_d;
      a_valid_q   <= a_mask_c;
      b_valid_q   <= b_mask_c;
    end
  end

  assign busy         = busy_q;
  assign pe_clear     = pe_clear_q;
  assign feed_t       = feed_t_q;
  assign a_valid      = a_valid_q;
  assign b_valid      = b_valid_q;
  assign result_valid = done_q;
  assign done         = done_q;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Directed, table-driven bench for systolic_tile_sequencer (ROWS=COLS=4, KW=8).
module tb_systolic_tile_sequencer;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned KW   = 8;

  typedef struct {
    int         cyc;
    logic       busy;
    logic       clr;
    logic [8:0] ft;
    logic [3:0] av;
    logic [3:0] bv;
    logic       dn;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            abort;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            pe_clear;
  logic [KW:0]     feed_t;
  logic [ROWS-1:0] a_valid;
  logic [COLS-1:0] b_valid;
  logic            result_valid;
  logic            done;

  int checks = 0;
  int errors = 0;
  vec_t tv[$];
  int   pokes[$];

  systolic_tile_sequencer #(.ROWS(ROWS), .COLS(COLS), .KW(KW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .k_len        (k_len),
    .busy         (busy),
    .pe_clear     (pe_clear),
    .feed_t       (feed_t),
    .a_valid      (a_valid),
    .b_valid      (b_valid),
    .result_valid (result_valid),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int c, input logic bz, input logic cl, input int f,
                              input logic [3:0] a, input logic [3:0] b, input logic d);
    vec_t v;
    v.cyc = c; v.busy = bz; v.clr = cl; v.ft = 9'(f); v.av = a; v.bv = b; v.dn = d;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc%0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input vec_t v);
    chk({tag, ".busy"},     c, 32'(busy),         32'(v.busy));
    chk({tag, ".pe_clear"}, c, 32'(pe_clear),     32'(v.clr));
    chk({tag, ".feed_t"},   c, 32'(feed_t),       32'(v.ft));
    chk({tag, ".a_valid"},  c, 32'(a_valid),      32'(v.av));
    chk({tag, ".b_valid"},  c, 32'(b_valid),      32'(v.bv));
    chk({tag, ".done"},     c, 32'(done),         32'(v.dn));
    chk({tag, ".rvalid"},   c, 32'(result_valid), 32'(v.dn));
  endtask

  // Start a tile in cycle 0 and compare table rows; pokes re-assert start mid-tile.
  task automatic run_seq(input string tag, input logic [7:0] kl, input int ncyc, input int done_cyc);
    start = 1'b1;
    k_len = kl;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start = 1'b0;
      k_len = 8'd3;
      foreach (tv[i]) if (tv[i].cyc == c) chk_all(tag, c, tv[i]);
      chk({tag, ".done_only"}, c, 32'(done), 32'(c == done_cyc));
      foreach (pokes[i]) if (pokes[i] == c) start = 1'b1;
    end
    start = 1'b0;
    tv.delete();
    pokes.delete();
  endtask

  initial begin
    vec_t zero_v;
    zero_v = mk(0, 0, 0, 0, 4'h0, 4'h0, 0);
    reset = 1'b1; start = 1'b0; abort = 1'b0; k_len = '0;
    #3;
    chk_all("reset", 0, zero_v);
    step(); step();
    reset = 1'b0;
    step();
    chk_all("post_reset", 0, zero_v);

    // Nominal k_len=8 with start pokes while in FEED and in DONE.
    tv.push_back(mk(1,  1, 1, 0,  4'h0, 4'h0, 0));
    tv.push_back(mk(2,  1, 0, 0,  4'h1, 4'h1, 0));
    tv.push_back(mk(3,  1, 0, 1,  4'h3, 4'h3, 0));
    tv.push_back(mk(5,  1, 0, 3,  4'hF, 4'hF, 0));
    tv.push_back(mk(10, 1, 0, 8,  4'hE, 4'hE, 0));
    tv.push_back(mk(11, 1, 0, 9,  4'hC, 4'hC, 0));
    tv.push_back(mk(12, 1, 0, 10, 4'h8, 4'h8, 0));
    tv.push_back(mk(13, 1, 0, 0,  4'h0, 4'h0, 0));
    tv.push_back(mk(19, 1, 0, 0,  4'h0, 4'h0, 0));
    tv.push_back(mk(20, 1, 0, 0,  4'h0, 4'h0, 1));
    tv.push_back(mk(21, 0, 0, 0,  4'h0, 4'h0, 0));
    tv.push_back(mk(22, 0, 0, 0,  4'h0, 4'h0, 0));
    pokes.push_back(8);
    pokes.push_back(20);
    run_seq("nominal", 8'd8, 22, 20);

    // Zero depth skips FEED entirely.
    tv.push_back(mk(1,  1, 1, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(2,  1, 0, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(8,  1, 0, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(9,  1, 0, 0, 4'h0, 4'h0, 1));
    tv.push_back(mk(10, 0, 0, 0, 4'h0, 4'h0, 0));
    run_seq("zero", 8'd0, 10, 9);

    // Abort in FEED at cycle 6 returns to IDLE without done.
    start = 1'b1; k_len = 8'd8;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      abort = (c == 6);
      if (c == 5) chk("abort.pre_ft", c, 32'(feed_t), 32'd3);
      if (c == 7) chk_all("abort", c, zero_v);
      chk("abort.no_done", c, 32'(done), 32'd0);
    end
    abort = 1'b0;

    // Abort beats a same-cycle start in IDLE.
    start = 1'b1; abort = 1'b1; k_len = 8'd8;
    step();
    start = 1'b0; abort = 1'b0;
    chk_all("abort_start", 1, zero_v);
    step();
    chk("abort_start.busy2", 2, 32'(busy), 32'd0);

    // New start accepted after abort.
    tv.push_back(mk(1, 1, 1, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(9, 1, 0, 0, 4'h0, 4'h0, 1));
    run_seq("after_abort", 8'd0, 10, 9);

    // Async reset mid-tile clears outputs immediately.
    start = 1'b1; k_len = 8'd8;
    for (int c = 1; c <= 5; c++) begin
      step();
      start = 1'b0;
    end
    chk("rst_mid.pre_busy", 5, 32'(busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("rst_mid", 5, zero_v);
    step();
    reset = 1'b0;
    step();
    chk_all("rst_mid.idle", 0, zero_v);

    // k_len=1 after reset: single-cycle diagonal, done at cycle 13.
    tv.push_back(mk(1,  1, 1, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(2,  1, 0, 0, 4'h1, 4'h1, 0));
    tv.push_back(mk(3,  1, 0, 1, 4'h2, 4'h2, 0));
    tv.push_back(mk(5,  1, 0, 3, 4'h8, 4'h8, 0));
    tv.push_back(mk(6,  1, 0, 0, 4'h0, 4'h0, 0));
    tv.push_back(mk(13, 1, 0, 0, 4'h0, 4'h0, 1));
    tv.push_back(mk(14, 0, 0, 0, 4'h0, 4'h0, 0));
    run_seq("k1", 8'd1, 14, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
